note_sprite_renderer: RTL
=========================

NOTE_SPRITE_RENDERER -- requirements
Module: note_sprite_renderer

Interface
REQ-001 Parameter SPRITE_W, default 20, meaning sprite width in pixels.
REQ-002 Parameter SPRITE_H, default 30, meaning sprite height in pixels.
REQ-003 Parameter NUM_SLOTS, default 8, meaning number of on-screen note slots.
REQ-004 clk  input  1  meaning single system/pixel clock; all logic on posedge.
REQ-005 reset_n  input  1  meaning synchronous active-low reset.
REQ-006 wr_en  input  1  meaning slot-table write strobe, one write per cycle.
REQ-007 wr_slot  input  3  meaning slot index to write.
REQ-008 wr_x  input  10  meaning sprite left column.
REQ-009 wr_y  input  10  meaning sprite top row.
REQ-010 wr_vis  input  1  meaning slot visible flag.
REQ-011 frame_start  input  1  meaning one-cycle pulse at vertical blank; commits the shadow table.
REQ-012 in_valid  input  1  meaning hcount/vcount qualify an active pixel.
REQ-013 hcount  input  10  meaning current pixel column.
REQ-014 vcount  input  10  meaning current pixel row.
REQ-015 rom_addr  output  10  meaning address to the sprite ROM (row*SPRITE_W+col).
REQ-016 rom_pixel  input  1  meaning ROM data, valid one clk after rom_addr.
REQ-017 out_valid  output  1  meaning out_* qualify a pixel.
REQ-018 out_pix  output  1  meaning note ink present at this pixel.
REQ-019 out_slot  output  3  meaning slot that produced out_pix (0 when out_pix=0).

Function
REQ-020 Block SHALL hold a shadow table and an active table, NUM_SLOTS entries each of {x,y,vis}.
REQ-021 wr_en SHALL write {wr_x,wr_y,wr_vis} into shadow[wr_slot] at the clock edge; repeated writes before commit: last wins.
REQ-022 frame_start SHALL copy the whole shadow table to the active table in one cycle.
REQ-023 wr_en and frame_start in the same cycle SHALL commit the shadow including that write (write forwarded into active).
REQ-024 Pixel matching SHALL use only the active table; mid-frame shadow writes SHALL NOT affect rendering.
REQ-025 Slot i hits when vis_i=1, x_i<=hcount<x_i+SPRITE_W, y_i<=vcount<y_i+SPRITE_H, compared in 11-bit unsigned arithmetic (no wrap at 1023).
REQ-026 Multiple hits SHALL resolve to the lowest slot index.
REQ-027 Stage 1 (cycle N+1): register hit, slot, in_valid; rom_addr=(vcount-y_s)*SPRITE_W+(hcount-x_s) of winning slot, else 0.
REQ-028 Stage 2 (cycle N+2): rom_pixel arrives; delay hit/slot/valid one more register.
REQ-029 Stage 3 (cycle N+3): out_valid=valid_d2; out_pix=valid_d2&hit_d2&rom_pixel; out_slot=out_pix?slot_d2:0; fixed latency 3 clocks.
REQ-030 Pipeline SHALL accept a new pixel every cycle with no stall; in_valid=0 propagates as out_valid=0, out_pix=0.
REQ-031 rom_addr SHALL never exceed SPRITE_W*SPRITE_H-1 (599 at defaults).
REQ-032 Sprites partly beyond column 639/row 479 SHALL be clipped by the hit test only; no special handling.
REQ-033 frame_start mid-line SHALL take effect for pixels entering stage 1 on the following cycle; in-flight pixels complete with old table.

Reset
REQ-034 reset_n=0 at a clock edge SHALL clear all vis bits in both tables, all pipeline valid/hit bits, rom_addr=0, out_valid=0, out_pix=0, out_slot=0.
REQ-035 x/y table contents need not be cleared by reset.
REQ-036 Reset asserted mid-frame SHALL drop in-flight pixels; first output after release is valid no earlier than 3 cycles after first in_valid.

Verification
REQ-037 Write slot0 x=100,y=50,vis=1, pulse frame_start, scan (100..119,50..79) -> rom_addr 0..599 in raster order, out_pix equals ROM bit 3 cycles after input.
REQ-038 Slot2 x=200,y=60 and slot5 x=205,y=60 both visible, pixel (210,70) -> out_slot=2, rom_addr=10*20+10=210.
REQ-039 Write slot1 vis=1 without frame_start, scan its area -> out_pix=0; after frame_start -> sprite drawn.
REQ-040 wr_en slot3 x=0,y=0,vis=1 in same cycle as frame_start, pixel (0,0) next cycle -> hit slot 3, rom_addr=0.
REQ-041 Slot0 x=1015,y=470, pixel (1015..1023,470) hit, hcount wrap 0 -> no hit; rom_addr stays <=599.
REQ-042 reset_n low for 1 cycle mid-scan with in_valid=1 -> out_valid=0, out_pix=0 for 3 cycles after release; all slots invisible until rewritten and committed.

Source files
------------

// File: rtl/note_sprite_renderer.sv
// Note sprite renderer: double-buffered slot table plus a 3-stage pixel pipeline.
// Stage 1 does the hit test and drives the sprite ROM address. Stage 2 waits for ROM data.
// Stage 3 registers the final ink/slot outputs.
module note_sprite_renderer #(
  parameter int unsigned SPRITE_W  = 20,
  parameter int unsigned SPRITE_H  = 30,
  parameter int unsigned NUM_SLOTS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [2:0] wr_slot,
  input  logic [9:0] wr_x,
  input  logic [9:0] wr_y,
  input  logic       wr_vis,
  input  logic       frame_start,
  input  logic       in_valid,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  output logic [9:0] rom_addr,
  input  logic       rom_pixel,
  output logic       out_valid,
  output logic       out_pix,
  output logic [2:0] out_slot
);

  logic [9:0] r_sh_x   [NUM_SLOTS];
  logic [9:0] r_sh_y   [NUM_SLOTS];
  logic       r_sh_vis [NUM_SLOTS];
  logic [9:0] r_ac_x   [NUM_SLOTS];
  logic [9:0] r_ac_y   [NUM_SLOTS];
  logic       r_ac_vis [NUM_SLOTS];

  logic       w_hit;
  logic [2:0] w_slot;
  logic [9:0] w_sel_x;
  logic [9:0] w_sel_y;
  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic [9:0] w_addr;

  logic       r_v1, r_h1;
  logic [2:0] r_s1;
  logic [9:0] r_addr1;
  logic       r_v2, r_h2;
  logic [2:0] r_s2;
  logic       r_ov, r_op;
  logic [2:0] r_os;

  // Shadow coordinates: host writes land here; last write before commit wins.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (wr_en && wr_slot == 3'(i)) begin
        r_sh_x[i] <= wr_x;
        r_sh_y[i] <= wr_y;
      end
    end
  end

  // Shadow visibility: cleared by reset so nothing draws until rewritten.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!reset_n) begin
        r_sh_vis[i] <= 1'b0;
      end else if (wr_en && wr_slot == 3'(i)) begin
        r_sh_vis[i] <= wr_vis;
      end
    end
  end

  // Active coordinates: whole-table commit, forwarding a same-cycle write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (frame_start) begin
        if (wr_en && wr_slot == 3'(i)) begin
          r_ac_x[i] <= wr_x;
          r_ac_y[i] <= wr_y;
        end else begin
          r_ac_x[i] <= r_sh_x[i];
          r_ac_y[i] <= r_sh_y[i];
        end
      end
    end
  end

  // Active visibility: same commit/forwarding rule, cleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!reset_n) begin
        r_ac_vis[i] <= 1'b0;
      end else if (frame_start) begin
        r_ac_vis[i] <= (wr_en && wr_slot == 3'(i)) ? wr_vis : r_sh_vis[i];
      end
    end
  end

  // Hit test in 11 bits so sprites near column/row 1023 do not wrap; descending scan
  // lets the lowest matching slot win.
  always_comb begin
    w_hit   = 1'b0;
    w_slot  = 3'd0;
    w_sel_x = 10'd0;
    w_sel_y = 10'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (r_ac_vis[i] &&
          ({1'b0, hcount} >= {1'b0, r_ac_x[i]}) &&
          ({1'b0, hcount} <  {1'b0, r_ac_x[i]} + 11'(SPRITE_W)) &&
          ({1'b0, vcount} >= {1'b0, r_ac_y[i]}) &&
          ({1'b0, vcount} <  {1'b0, r_ac_y[i]} + 11'(SPRITE_H))) begin
        w_hit   = 1'b1;
        w_slot  = 3'(i);
        w_sel_x = r_ac_x[i];
        w_sel_y = r_ac_y[i];
      end
    end
  end

  // Offsets are only meaningful on a hit, where they are bounded by the sprite size.
  assign w_dx   = hcount - w_sel_x;
  assign w_dy   = vcount - w_sel_y;
  assign w_addr = w_dy * 10'(SPRITE_W) + w_dx;

  // Stage 1: register hit result and ROM address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_h1    <= 1'b0;
      r_s1    <= 3'd0;
      r_addr1 <= 10'd0;
    end else begin
      r_v1    <= in_valid;
      r_h1    <= in_valid & w_hit;
      r_s1    <= (in_valid && w_hit) ? w_slot : 3'd0;
      r_addr1 <= (in_valid && w_hit) ? w_addr : 10'd0;
    end
  end

  // Stage 2: align hit/slot/valid with ROM data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_v2 <= 1'b0;
      r_h2 <= 1'b0;
      r_s2 <= 3'd0;
    end else begin
      r_v2 <= r_v1;
      r_h2 <= r_h1;
      r_s2 <= r_s1;
    end
  end

  // Stage 3: combine with ROM ink and register outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ov <= 1'b0;
      r_op <= 1'b0;
      r_os <= 3'd0;
    end else begin
      r_ov <= r_v2;
      r_op <= r_v2 & r_h2 & rom_pixel;
      r_os <= (r_v2 && r_h2 && rom_pixel) ? r_s2 : 3'd0;
    end
  end

  assign rom_addr  = r_addr1;
  assign out_valid = r_ov;
  assign out_pix   = r_op;
  assign out_slot  = r_os;

endmodule
